asmi_flash_responder: RTL and testbench



---
 rtl/asmi_resp_pkg.sv | 21 ++
 rtl/asmi_pin_sync.sv | 36 +++
 rtl/asmi_flash_responder.sv | 159 +++++++++++++++
 tb/tb_asmi_flash_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/asmi_resp_pkg.sv
// asmi_resp_pkg: ASMI opcodes, responder FSM states, status bit positions and CRC-16 step
package asmi_resp_pkg;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_RSIID = 8'hAB;
  localparam logic [7:0] OP_RDI   = 8'h9F;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_PP    = 8'h02;
  localparam logic [7:0] OP_SE    = 8'hD8;
  localparam logic [7:0] OP_BE    = 8'hC7;
  localparam int STAT_WIP = 0;
  localparam int STAT_WEL = 1;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  typedef enum logic [2:0] {
    ST_IDLE, ST_OPCODE, ST_ADDR, ST_DUMMY, ST_DATA_OUT, ST_DATA_IN, ST_IGNORE
  } state_t;
  function automatic logic [15:0] crc16_bit(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC_POLY : 16'h0000);
  endfunction
endpackage

// File: rtl/asmi_pin_sync.sv
// asmi_pin_sync: 2-flop synchronisers on the ASMI pins plus edge strobes (dclk edges gated by chip select)
module asmi_pin_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic dclkin,
  input  logic scein,
  input  logic sdoin,
  output logic dclk_rise,
  output logic dclk_fall,
  output logic sce_fall,
  output logic sce_rise,
  output logic sdo
);
  logic [2:0] d_s;
  logic [2:0] c_s;
  logic [1:0] s_s;
  // two sync stages plus one history stage for edge detection
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      d_s <= 3'b000;
      c_s <= 3'b111;
      s_s <= 2'b00;
    end else begin
      d_s <= {d_s[1:0], dclkin};
      c_s <= {c_s[1:0], scein};
      s_s <= {s_s[0], sdoin};
    end
  // strobes are one clk wide; dclk edges only count while selected
  always_comb begin
    sdo       = s_s[1];
    dclk_rise = d_s[1] & ~d_s[2] & ~c_s[1];
    dclk_fall = ~d_s[1] & d_s[2] & ~c_s[1];
    sce_fall  = ~c_s[1] & c_s[2];
    sce_rise  = c_s[1] & ~c_s[2];
  end
endmodule

// File: rtl/asmi_flash_responder.sv
// asmi_flash_responder: ASMI serial-flash target model (optional READ CRC via ASMI_RESP_CRC_EN)
module asmi_flash_responder
  import asmi_resp_pkg::*;
#(
  parameter int         MEM_ADDR_WIDTH = 17,
  parameter int         SECTOR_BITS    = 16,
  parameter int         PAGE_BITS      = 8,
  parameter logic [7:0] SILICON_ID     = 8'h10,
  parameter logic [7:0] DEVICE_ID      = 8'h20,
  parameter int         PROG_CYCLES    = 64,
  parameter int         ERASE_CYCLES   = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dclkin,
  input  logic        scein,
  input  logic        sdoin,
  output logic        data0out,
  output logic        wip,
  output logic        wel,
  output logic        cmd_error,
  output logic [15:0] crc_value
);
  localparam int AW = MEM_ADDR_WIDTH;
  localparam int CW = $clog2(PROG_CYCLES > ERASE_CYCLES ? PROG_CYCLES : ERASE_CYCLES);
  localparam logic [AW-1:0] SEC_MASK = AW'((64'd1 << SECTOR_BITS) - 64'd1);
  state_t state, state_d;
  logic rise, fall, sfall, srise, sdo;
  logic [AW-2:0] sh;
  logic [AW-1:0] sh_d, addr, wptr, wlast;
  logic [7:0] op, opc, live, stat_lat, cur_byte, rd_data;
  logic [5:0] tot;
  logic [4:0] ph, ph_last;
  logic [2:0] ocnt;
  logic [PAGE_BITS-1:0] pg_ptr;
  logic [CW-1:0] busy;
  logic op_ok, dec_ok, pp_any, ph_end, pp_we, cur_bit, err_d, commit_err, commit;
  logic set_wel, clr_wel, start_prog, start_se, start_be, done, erasing;
  logic [7:0] mem [0:(1<<AW)-1];
  asmi_pin_sync u_sync (
    .clk(clk), .reset_n(reset_n), .dclkin(dclkin), .scein(scein), .sdoin(sdoin),
    .dclk_rise(rise), .dclk_fall(fall), .sce_fall(sfall), .sce_rise(srise), .sdo(sdo)
  );
  // the shift register is one bit short of an address so high ASMI address bits fall off (modulo wrap)
  assign sh_d = {sh, sdo};
  // FSM state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= ST_IDLE;
    else state <= state_d;
  // opcode decode, phase sequencing, error and commit decisions
  always_comb begin
    opc        = sh_d[7:0];
    dec_ok     = wip ? opc == OP_RDSR
                     : (opc inside {OP_WREN, OP_WRDI, OP_RDSR, OP_RSIID, OP_RDI, OP_READ}) ||
                       (wel && (opc inside {OP_PP, OP_SE, OP_BE}));
    ph_last    = state == ST_ADDR ? 5'd23 : state == ST_DUMMY ? (op == OP_RSIID ? 5'd23 : 5'd15) : 5'd7;
    ph_end     = rise && ph == ph_last;
    pp_we      = ph_end && state == ST_DATA_IN;
    state_d    = srise ? ST_IDLE : sfall ? ST_OPCODE : !ph_end ? state :
                 state == ST_OPCODE ? (!dec_ok ? ST_IGNORE : opc == OP_RDSR ? ST_DATA_OUT :
                                       (opc inside {OP_RSIID, OP_RDI}) ? ST_DUMMY :
                                       (opc inside {OP_READ, OP_PP, OP_SE}) ? ST_ADDR : ST_IGNORE) :
                 state == ST_ADDR ? (op == OP_READ ? ST_DATA_OUT : op == OP_PP ? ST_DATA_IN : ST_IGNORE) :
                 state == ST_DUMMY ? ST_DATA_OUT : state;
    commit_err = (state == ST_OPCODE && tot != 6'd0) ||
                 (op_ok && (((op inside {OP_WREN, OP_WRDI, OP_BE}) && tot != 6'd8) || (op == OP_SE && tot != 6'd32)));
    err_d      = (ph_end && state == ST_OPCODE && !dec_ok) || (srise && commit_err);
    commit     = srise && op_ok && !commit_err;
    set_wel    = commit && op == OP_WREN;
    clr_wel    = commit && op == OP_WRDI;
    start_prog = commit && op == OP_PP && pp_any;
    start_se   = commit && op == OP_SE;
    start_be   = commit && op == OP_BE;
    done       = wip && !erasing && busy == '0;
    live       = 8'h00;
    live[STAT_WEL] = wel;
    live[STAT_WIP] = wip;
    cur_byte   = op == OP_READ ? rd_data : op == OP_RSIID ? SILICON_ID : op == OP_RDI ? DEVICE_ID :
                 ocnt == 3'd0 ? live : stat_lat;
    cur_bit    = cur_byte[3'd7 - ocnt];
  end
  // shift/count logic, transaction context and serial output
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sh <= '0; tot <= '0; ph <= '0; op <= '0; op_ok <= 1'b0; addr <= '0; pg_ptr <= '0;
      pp_any <= 1'b0; ocnt <= '0; stat_lat <= '0; data0out <= 1'b0; cmd_error <= 1'b0;
    end else begin
      cmd_error <= err_d;
      data0out <= state_d == ST_DATA_OUT && (fall ? cur_bit : data0out);
      if (sfall) begin
        tot <= '0; ph <= '0; op_ok <= 1'b0; pp_any <= 1'b0; ocnt <= '0;
      end
      if (rise) begin
        sh  <= sh_d[AW-2:0];
        tot <= tot + {5'd0, tot != 6'd63};
        ph  <= ph_end ? 5'd0 : ph + 5'd1;
      end
      if (ph_end && state == ST_OPCODE) begin
        op    <= opc;
        op_ok <= dec_ok;
      end
      if (ph_end && state == ST_ADDR) begin
        addr   <= sh_d;
        pg_ptr <= sh_d[PAGE_BITS-1:0];
      end
      if (pp_we) begin
        pg_ptr <= pg_ptr + PAGE_BITS'(1);
        pp_any <= 1'b1;
      end
      if (fall && state == ST_DATA_OUT) begin
        ocnt <= ocnt + 3'd1;
        if (ocnt == 3'd0) stat_lat <= live;
        if (ocnt == 3'd7 && op == OP_READ) addr <= addr + AW'(1);
      end
    end
  // write latch, busy timer and erase walk
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wip <= 1'b0; wel <= 1'b0; erasing <= 1'b0; busy <= '0; wptr <= '0; wlast <= '0;
    end else begin
      wel <= set_wel | (wel & ~clr_wel & ~done);
      if (start_prog) begin
        wip  <= 1'b1;
        busy <= CW'(PROG_CYCLES - 1);
      end else if (start_se | start_be) begin
        wip     <= 1'b1;
        erasing <= 1'b1;
        wptr    <= start_be ? '0 : addr & ~SEC_MASK;
        wlast   <= start_be ? '1 : addr | SEC_MASK;
      end else if (erasing) begin
        wptr <= wptr + AW'(1);
        if (wptr == wlast) begin
          erasing <= 1'b0;
          busy    <= CW'(ERASE_CYCLES - 1);
        end
      end else if (done) wip <= 1'b0;
      else if (wip) busy <= busy - CW'(1);
    end
  // byte array: erase walk or program-AND write, registered read (contents survive reset)
  always_ff @(posedge clk) begin
    if (erasing) mem[wptr] <= 8'hFF;
    else if (pp_we) mem[{addr[AW-1:PAGE_BITS], pg_ptr}] <= mem[{addr[AW-1:PAGE_BITS], pg_ptr}] & sh_d[7:0];
    rd_data <= mem[addr];
  end
`ifdef ASMI_RESP_CRC_EN
  logic [15:0] crc_acc;
  // CRC over each READ data bit as the loader samples it; published when the READ ends
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      crc_acc   <= 16'h0000;
      crc_value <= 16'h0000;
    end else begin
      crc_acc <= sfall ? 16'h0000 : (rise && state == ST_DATA_OUT && op == OP_READ) ? crc16_bit(crc_acc, data0out) : crc_acc;
      if (srise && op_ok && op == OP_READ) crc_value <= crc_acc;
    end
`else
  assign crc_value = 16'h0000;
`endif
endmodule

// File: tb/tb_asmi_flash_responder.sv
// tb_asmi_flash_responder: directed ASMI loader stimulus with expected-byte scoreboard
module tb_asmi_flash_responder;
  logic clk = 1'b0, reset_n = 1'b0, dclkin = 1'b0, scein = 1'b1, sdoin = 1'b0;
  logic data0out, wip, wel, cmd_error;
  logic [15:0] crc_value;
  int total = 0, bad = 0, err_cnt = 0, wip_cnt = 0, e0 = 0, w0 = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic rx_bits[$];
  asmi_flash_responder #(.MEM_ADDR_WIDTH(14), .SECTOR_BITS(13)) dut (
    .clk(clk), .reset_n(reset_n), .dclkin(dclkin), .scein(scein), .sdoin(sdoin),
    .data0out(data0out), .wip(wip), .wel(wel), .cmd_error(cmd_error), .crc_value(crc_value)
  );
  always #5 clk = ~clk;
  // free-running event counters sampled away from the active edge
  always @(negedge clk) begin
    if (cmd_error) err_cnt++;
    if (wip) wip_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask
  task automatic xfer(input int nbits);
    rx_bits.delete();
    scein = 1'b0;
    #80;
    for (int i = 0; i < nbits; i++) begin
      sdoin = (i / 8 < tx_q.size()) ? tx_q[i/8][7-(i%8)] : 1'b0;
      #80;
      rx_bits.push_back(data0out);
      dclkin = 1'b1;
      #80;
      dclkin = 1'b0;
    end
    #80;
    scein = 1'b1;
    sdoin = 1'b0;
    tx_q.delete();
    #160;
  endtask
  task automatic chk_rx(input string tag, input int skip);
    int k = 0;
    while (exp_q.size() > 0) begin
      logic [7:0] b, e;
      e = exp_q.pop_front();
      b = 8'h00;
      for (int j = 0; j < 8; j++) b = {b[6:0], rx_bits[skip+8*k+j]};
      chk(tag, {24'h0, b}, {24'h0, e});
      k++;
    end
  endtask
  task automatic hdr(input logic [7:0] o, input logic [23:0] a);
    tx_q.push_back(o);
    tx_q.push_back(a[23:16]);
    tx_q.push_back(a[15:8]);
    tx_q.push_back(a[7:0]);
  endtask
  task automatic op1(input logic [7:0] o, input int nbits);
    tx_q.push_back(o);
    xfer(nbits);
  endtask
  task automatic rdsr(input string tag, input logic [7:0] e);
    exp_q.push_back(e);
    op1(8'h05, 16);
    chk_rx(tag, 8);
  endtask
  task automatic rd(input string tag, input logic [23:0] a);
    int n = exp_q.size();
    hdr(8'h03, a);
    xfer(32 + 8 * n);
    chk_rx(tag, 32);
  endtask
  task automatic wait_wip_low(input int maxc);
    int n = 0;
    while (wip && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("wip_timeout", {31'h0, wip}, 32'h0);
  endtask
  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) c = (c[15] ^ b[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    return c;
  endfunction
  initial begin
    #100 reset_n = 1'b1;
    #100;
    chk("rst_d0", {31'h0, data0out}, 0);
    chk("rst_wip", {31'h0, wip}, 0);
    chk("rst_wel", {31'h0, wel}, 0);
    chk("rst_err", {31'h0, cmd_error}, 0);
    chk("rst_crc", {16'h0, crc_value}, 0);
    op1(8'h06, 8);
    op1(8'hC7, 8);
    chk("be_wip", {31'h0, wip}, 1);
    rdsr("rdsr_be", 8'h03);
    wait_wip_low(20000);
    rdsr("rdsr_after_be", 8'h00);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h10);
    op1(8'hAB, 48);
    chk_rx("rsiid", 32);
    exp_q.push_back(8'h20);
    op1(8'h9F, 32);
    chk_rx("rdi", 24);
    op1(8'h06, 8);
    rdsr("rdsr_wel", 8'h02);
    w0 = wip_cnt;
    hdr(8'h02, 24'h0000FE);
    tx_q.push_back(8'h12);
    tx_q.push_back(8'h34);
    tx_q.push_back(8'h56);
    xfer(56);
    chk("pp_wip", {31'h0, wip}, 1);
    wait_wip_low(1000);
    chk("pp_wip_len", wip_cnt - w0, 64);
    rdsr("rdsr_after_pp", 8'h00);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    rd("rd_fe", 24'h0000FE);
`ifdef ASMI_RESP_CRC_EN
    chk("crc", {16'h0, crc_value}, {16'h0, crc_ref(crc_ref(16'h0, 8'h12), 8'h34)});
`endif
    exp_q.push_back(8'h56);
    rd("rd_wrap_page", 24'h000000);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'hFF);
    rd("rd_cross", 24'h0000FF);
    e0 = err_cnt;
    hdr(8'h02, 24'h000010);
    tx_q.push_back(8'h00);
    xfer(40);
    chk("pp_nowel_err", err_cnt - e0, 1);
    chk("pp_nowel_wip", {31'h0, wip}, 0);
    exp_q.push_back(8'hFF);
    rd("rd_nowel", 24'h000010);
    op1(8'h06, 8);
    hdr(8'h02, 24'h000020);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'hF0);
    xfer(48 + 3);
    wait_wip_low(1000);
    op1(8'h06, 8);
    hdr(8'h02, 24'h000020);
    tx_q.push_back(8'hFF);
    tx_q.push_back(8'h3C);
    xfer(48);
    wait_wip_low(1000);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'hFF);
    rd("rd_and", 24'h000020);
    op1(8'h06, 8);
    hdr(8'h02, 24'h002005);
    tx_q.push_back(8'hA5);
    xfer(40);
    wait_wip_low(1000);
    exp_q.push_back(8'hA5);
    rd("rd_sec1", 24'h002005);
    op1(8'h06, 8);
    hdr(8'hD8, 24'h002000);
    xfer(32);
    rdsr("rdsr_se", 8'h03);
    e0 = err_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    rd("rd_busy_d0", 24'h0000FE);
    chk("rd_busy_err", err_cnt - e0, 1);
    wait_wip_low(12000);
    rdsr("rdsr_after_se", 8'h00);
    exp_q.push_back(8'hFF);
    rd("rd_erased", 24'h002005);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h56);
    rd("rd_top_wrap", 24'h013FFF);
    exp_q.push_back(8'h12);
    rd("rd_sec0_kept", 24'h0000FE);
    e0 = err_cnt;
    op1(8'h06, 9);
    chk("wren_bits_err", err_cnt - e0, 1);
    chk("wren_bits_wel", {31'h0, wel}, 0);
    e0 = err_cnt;
    op1(8'h55, 8);
    chk("unknown_err", err_cnt - e0, 1);
    e0 = err_cnt;
    op1(8'h06, 8);
    op1(8'hD8, 8);
    chk("se_bits_err", err_cnt - e0, 1);
    chk("se_bits_wip", {31'h0, wip}, 0);
    op1(8'h04, 8);
    rdsr("rdsr_wrdi", 8'h00);
    op1(8'h06, 8);
    op1(8'hC7, 8);
    #2000;
    chk("be2_wip", {31'h0, wip}, 1);
    reset_n = 1'b0;
    #20;
    chk("mid_rst_wip", {31'h0, wip}, 0);
    chk("mid_rst_wel", {31'h0, wel}, 0);
    reset_n = 1'b1;
    #400;
    chk("post_rst_wip", {31'h0, wip}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
